// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired control sequencer (master) and the ALU-system datapath (slave).
// The Illegal line exists only when CONTROL_SEQUENCER_ILLEGAL_TRAP_EN is defined.
interface control_sequencer_if;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic [1:0]  MuxCSel;
  logic        MuxDSel;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Write;
  logic        Mem_WR;
  logic        Mem_CS;
  logic        DR_E;
  logic [1:0]  DR_FunSel;
  logic        Halted;
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  modport master (
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
    output Illegal,
`endif
    input  IROut, Flags,
    output MuxASel, MuxBSel, MuxCSel, MuxDSel,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
    output ALU_FunSel, ALU_WF,
    output ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
    output IR_LH, IR_Write, Mem_WR, Mem_CS, DR_E, DR_FunSel, Halted
  );

  modport slave (
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
    input  Illegal,
`endif
    output IROut, Flags,
    input  MuxASel, MuxBSel, MuxCSel, MuxDSel,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
    input  ALU_FunSel, ALU_WF,
    input  ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
    input  IR_LH, IR_Write, Mem_WR, Mem_CS, DR_E, DR_FunSel, Halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the datapath control bus.
// Optional macro CONTROL_SEQUENCER_ILLEGAL_TRAP_EN: undefined opcodes halt and raise Illegal.
module control_sequencer (
  input  logic                i_clk,
  input  logic                i_rst_n,
  control_sequencer_if.master bus
);
  localparam logic [1:0] ARF_SEL_PC   = 2'b00;
  localparam logic [1:0] ARF_SEL_AR   = 2'b10;
  localparam logic [1:0] ARF_FUN_INC  = 2'b01;
  localparam logic [1:0] ARF_FUN_LOAD = 2'b10;
  localparam logic [2:0] RF_FUN_LOAD  = 3'b010;
  localparam logic [1:0] DR_FUN_LOAD  = 2'b01;
  localparam logic [1:0] DR_FUN_SHL   = 2'b10;
  localparam logic       MEM_CS_ACT   = 1'b0;

  typedef enum logic [2:0] {F_LO, F_HI, EX1, EX2, EX3, HALT} state_t;

  state_t      r_state;
  logic [5:0]  w_op;
  logic        w_z;
  logic        w_is_bra, w_is_bne, w_is_beq, w_is_movl, w_is_alu, w_is_ldw, w_is_hlt;
  logic        w_defined;
  logic        w_taken;

  // Register fields name R1..R4; bit3 of RegSel is R1, bit0 is R4.
  function automatic logic [3:0] f_onehot(input logic [1:0] i_field);
    logic [3:0] v;
    case (i_field)
      2'd0:    v = 4'b1000;
      2'd1:    v = 4'b0100;
      2'd2:    v = 4'b0010;
      2'd3:    v = 4'b0001;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  assign w_op      = bus.IROut[15:10];
  assign w_z       = bus.Flags[3];
  assign w_is_bra  = (w_op == 6'h00);
  assign w_is_bne  = (w_op == 6'h01);
  assign w_is_beq  = (w_op == 6'h02);
  assign w_is_movl = (w_op == 6'h04);
  assign w_is_ldw  = (w_op == 6'h05);
  assign w_is_alu  = (w_op[5:4] == 2'b01);
  assign w_is_hlt  = (w_op == 6'h3F);
  assign w_defined = w_is_bra | w_is_bne | w_is_beq | w_is_movl | w_is_ldw | w_is_alu | w_is_hlt;
  assign w_taken   = w_is_bra | (w_is_bne & ~w_z) | (w_is_beq & w_z);

`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  logic r_illegal;
  // Sticky trap flag; the combinational term makes Illegal visible in the offending EX1 cycle.
  assign bus.Illegal = i_rst_n & (r_illegal | ((r_state == EX1) & ~w_defined));
`endif

  // State sequencing; reset always restarts at the low-byte fetch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= F_LO;
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        F_LO: r_state <= F_HI;
        F_HI: r_state <= EX1;
        EX1: begin
          if (w_is_hlt) begin
            r_state <= HALT;
          end else if (w_is_ldw) begin
            r_state <= EX2;
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
          end else if (!w_defined) begin
            r_state   <= HALT;
            r_illegal <= 1'b1;
`endif
          end else begin
            r_state <= F_LO;
          end
        end
        EX2:     r_state <= EX3;
        EX3:     r_state <= F_LO;
        HALT:    r_state <= HALT;
        default: r_state <= F_LO;
      endcase
    end
  end

  // Control word decode from state and IR; gated idle while reset is held.
  always_comb begin
    bus.MuxASel     = 2'b00;
    bus.MuxBSel     = 2'b00;
    bus.MuxCSel     = 2'b00;
    bus.MuxDSel     = 1'b0;
    bus.RF_OutASel  = 3'b000;
    bus.RF_OutBSel  = 3'b000;
    bus.RF_FunSel   = 3'b000;
    bus.RF_RegSel   = 4'b0000;
    bus.RF_ScrSel   = 4'b0000;
    bus.ALU_FunSel  = 5'b00000;
    bus.ALU_WF      = 1'b0;
    bus.ARF_OutCSel = 2'b00;
    bus.ARF_OutDSel = 2'b00;
    bus.ARF_FunSel  = 2'b00;
    bus.ARF_RegSel  = 3'b000;
    bus.IR_LH       = 1'b0;
    bus.IR_Write    = 1'b0;
    bus.Mem_WR      = 1'b0;
    bus.Mem_CS      = ~MEM_CS_ACT;
    bus.DR_E        = 1'b0;
    bus.DR_FunSel   = 2'b00;
    bus.Halted      = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        F_LO, F_HI: begin
          bus.Mem_CS      = MEM_CS_ACT;
          bus.ARF_OutDSel = ARF_SEL_PC;
          bus.IR_Write    = 1'b1;
          bus.IR_LH       = (r_state == F_HI);
          bus.ARF_RegSel  = 3'b100;
          bus.ARF_FunSel  = ARF_FUN_INC;
        end
        EX1: begin
          if (w_is_alu) begin
            bus.ALU_FunSel = {1'b1, w_op[3:0]};
            bus.RF_OutASel = {1'b0, bus.IROut[3:2]};
            bus.RF_OutBSel = {1'b0, bus.IROut[1:0]};
            bus.ALU_WF     = bus.IROut[9];
            bus.RF_FunSel  = RF_FUN_LOAD;
            bus.RF_RegSel  = f_onehot(bus.IROut[5:4]);
          end else if (w_is_movl) begin
            bus.MuxASel   = 2'b11;
            bus.RF_FunSel = RF_FUN_LOAD;
            bus.RF_RegSel = f_onehot(bus.IROut[9:8]);
          end else if (w_is_ldw) begin
            bus.Mem_CS      = MEM_CS_ACT;
            bus.ARF_OutDSel = ARF_SEL_AR;
            bus.DR_E        = 1'b1;
            bus.DR_FunSel   = DR_FUN_LOAD;
            bus.ARF_RegSel  = 3'b001;
            bus.ARF_FunSel  = ARF_FUN_INC;
          end else if (w_taken) begin
            bus.MuxBSel    = 2'b11;
            bus.ARF_RegSel = 3'b100;
            bus.ARF_FunSel = ARF_FUN_LOAD;
          end else begin
            bus.Halted = 1'b0;
          end
        end
        EX2: begin
          bus.Mem_CS      = MEM_CS_ACT;
          bus.ARF_OutDSel = ARF_SEL_AR;
          bus.DR_E        = 1'b1;
          bus.DR_FunSel   = DR_FUN_SHL;
          bus.ARF_RegSel  = 3'b001;
          bus.ARF_FunSel  = ARF_FUN_INC;
        end
        EX3: begin
          bus.MuxASel   = 2'b10;
          bus.RF_FunSel = RF_FUN_LOAD;
          bus.RF_RegSel = f_onehot(bus.IROut[9:8]);
        end
        HALT:    bus.Halted = 1'b1;
        default: bus.Halted = 1'b0;
      endcase
    end else begin
      bus.Halted = 1'b0;
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: directed cycles push hand-computed control words; a negedge monitor pops and compares.
module tb_control_sequencer;
  logic clk;
  logic rst_n;
  control_sequencer_if bus();

  control_sequencer dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mux_a; logic [1:0] mux_b; logic [1:0] mux_c; logic mux_d;
    logic [2:0] rf_a; logic [2:0] rf_b; logic [2:0] rf_fun; logic [3:0] rf_reg; logic [3:0] rf_scr;
    logic [4:0] alu_fun; logic alu_wf;
    logic [1:0] arf_c; logic [1:0] arf_d; logic [1:0] arf_fun; logic [2:0] arf_reg;
    logic ir_lh; logic ir_wr; logic mem_wr; logic mem_cs; logic dr_e; logic [1:0] dr_fun;
    logic halted; logic illegal;
  } ctl_t;

  typedef struct { ctl_t exp; int id; } sb_t;
  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  vec_id = 0;

  function automatic ctl_t idle();
    ctl_t e;
    e = '0;
    e.mem_cs = 1'b1;
    return e;
  endfunction

  function automatic ctl_t fetch(input logic lh);
    ctl_t e;
    e = idle();
    e.mem_cs  = 1'b0;
    e.ir_wr   = 1'b1;
    e.ir_lh   = lh;
    e.arf_reg = 3'b100;
    e.arf_fun = 2'b01;
    return e;
  endfunction

  function automatic ctl_t sample();
    ctl_t g;
    g = {bus.MuxASel, bus.MuxBSel, bus.MuxCSel, bus.MuxDSel,
         bus.RF_OutASel, bus.RF_OutBSel, bus.RF_FunSel, bus.RF_RegSel, bus.RF_ScrSel,
         bus.ALU_FunSel, bus.ALU_WF,
         bus.ARF_OutCSel, bus.ARF_OutDSel, bus.ARF_FunSel, bus.ARF_RegSel,
         bus.IR_LH, bus.IR_Write, bus.Mem_WR, bus.Mem_CS, bus.DR_E, bus.DR_FunSel,
         bus.Halted, 1'b0};
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
    g.illegal = bus.Illegal;
`endif
    return g;
  endfunction

  // One clock cycle of stimulus with its expected control word.
  task automatic cyc(input logic rst, input logic [15:0] ir, input logic [3:0] fl, input ctl_t e);
    sb_t s;
    @(posedge clk);
    #1;
    rst_n     = rst;
    bus.IROut = ir;
    bus.Flags = fl;
    s.exp = e;
    s.id  = vec_id;
    vec_id++;
    sb.push_back(s);
  endtask

  task automatic fetch2();
    cyc(1'b1, bus.IROut, bus.Flags, fetch(1'b0));
    cyc(1'b1, bus.IROut, bus.Flags, fetch(1'b1));
  endtask

  // Monitor: compare the presented control word whenever an expectation is pending.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t s;
      ctl_t g;
      s = sb.pop_front();
      g = sample();
      checks++;
      if (g !== s.exp) begin
        errors++;
        $display("FAIL vec%0d: got %h expected %h", s.id, g, s.exp);
      end
    end
  end

  initial begin
    ctl_t e;
    rst_n     = 1'b0;
    bus.IROut = 16'h0000;
    bus.Flags = 4'b0000;

    // Reset state, then release into the low-byte fetch.
    cyc(1'b0, 16'h0000, 4'b0000, idle());
    fetch2();
    // Reset pulled mid-F_HI: idle during reset, F_LO after release.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    cyc(1'b0, 16'h0000, 4'b0000, idle());
    fetch2();
    // MOVL R2,0x5A lands in EX1 (fetch above already done).
    e = idle(); e.mux_a = 2'b11; e.rf_fun = 3'b010; e.rf_reg = 4'b0100;
    cyc(1'b1, 16'h115A, 4'b0000, e);
    // ADD S=1 R3=R1+R2
    fetch2();
    e = idle(); e.alu_fun = 5'h14; e.alu_wf = 1'b1; e.rf_a = 3'b000; e.rf_b = 3'b001;
    e.rf_fun = 3'b010; e.rf_reg = 4'b0010;
    cyc(1'b1, 16'h5221, 4'b0000, e);
    // BEQ taken (Z=1)
    fetch2();
    e = idle(); e.mux_b = 2'b11; e.arf_reg = 3'b100; e.arf_fun = 2'b10;
    cyc(1'b1, 16'h0820, 4'b1000, e);
    // BEQ not taken (Z=0): no writes
    fetch2();
    cyc(1'b1, 16'h0820, 4'b0111, idle());
    // BNE taken with Z=0, not taken with Z=1
    fetch2();
    cyc(1'b1, 16'h0420, 4'b0000, e);
    fetch2();
    cyc(1'b1, 16'h0420, 4'b1000, idle());
    // BRA taken regardless of flags
    fetch2();
    cyc(1'b1, 16'h0020, 4'b1111, e);
    // LDW R1: EX1, EX2, EX3, then fetch again
    fetch2();
    e = idle(); e.mem_cs = 1'b0; e.arf_d = 2'b10; e.dr_e = 1'b1; e.dr_fun = 2'b01;
    e.arf_reg = 3'b001; e.arf_fun = 2'b01;
    cyc(1'b1, 16'h1400, 4'b0000, e);
    e.dr_fun = 2'b10;
    cyc(1'b1, 16'h1400, 4'b0000, e);
    e = idle(); e.mux_a = 2'b10; e.rf_fun = 3'b010; e.rf_reg = 4'b1000;
    cyc(1'b1, 16'h1400, 4'b0000, e);
    cyc(1'b1, 16'h1400, 4'b0000, fetch(1'b0));
    // HLT: EX1 no writes, then Halted held with other outputs idle
    cyc(1'b1, 16'h1400, 4'b0000, fetch(1'b1));
    cyc(1'b1, 16'hFC00, 4'b0000, idle());
    e = idle(); e.halted = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, (i % 2 == 0) ? 16'h115A : 16'h1400, 4'(i), e);
    end
    // Reset out of HALT, then an undefined opcode
    cyc(1'b0, 16'h0000, 4'b0000, idle());
    fetch2();
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
    e = idle(); e.illegal = 1'b1;
    cyc(1'b1, 16'h3000, 4'b0000, e);
    e.halted = 1'b1;
    cyc(1'b1, 16'h3000, 4'b0000, e);
    cyc(1'b1, 16'h115A, 4'b0000, e);
`else
    cyc(1'b1, 16'h3000, 4'b0000, idle());
    cyc(1'b1, 16'h3000, 4'b0000, fetch(1'b0));
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
